// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the add/sub back end.
package fp_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  // Internal exponent is wide and signed so normalization never wraps.
  localparam int EXP_INT_W  = 10;
  typedef logic signed [EXP_INT_W-1:0] exp_int_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  localparam fp32_t POS_ZERO = 32'h0000_0000;
  localparam fp32_t POS_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fp_norm_round_if.sv
// Beat interface between the mantissa unit, this block and writeback.
// The slave view is the normalize/round block itself.
interface fp_norm_round_if #(
  parameter int SIZE_DATA = 28,
  parameter int SIZE_EXP  = 8
);
  logic                 i_valid;
  logic                 o_ready;
  logic                 i_sign;
  logic [SIZE_EXP-1:0]  i_exponent;
  logic [SIZE_DATA-1:0] i_mantissa;
  logic                 i_overflow;
  logic                 o_valid;
  logic                 i_ready;
  logic [31:0]          o_result;
  logic                 o_flag_ovf;
  logic                 o_flag_unf;
  logic                 o_flag_inexact;

  modport slave (
    input  i_valid, i_sign, i_exponent, i_mantissa, i_overflow, i_ready,
    output o_ready, o_valid, o_result, o_flag_ovf, o_flag_unf, o_flag_inexact
  );

  modport master (
    output i_valid, i_sign, i_exponent, i_mantissa, i_overflow, i_ready,
    input  o_ready, o_valid, o_result, o_flag_ovf, o_flag_unf, o_flag_inexact
  );
endinterface

// File: rtl/fp_norm_round_lzc_28.sv
// Combinational leading-zero counter for the 28-bit raw mantissa.
// An all-zero input reports a count of 28 and raises all_zero.
module lzc_28 (
  input  logic [27:0] value,
  output logic [4:0]  count,
  output logic        all_zero
);

  // Scan upward so the highest set bit is the last one to set the count.
  always_comb begin
    count    = 5'd28;
    all_zero = (value == 28'd0);
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalize and round-to-nearest-even back end of the FP adder.
// Three registered stages (capture+lzc, normalize, round/pack) with
// a valid/ready handshake that stalls each stage independently.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int SIZE_DATA = 28,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_FRAC = 23
) (
  input logic            i_clk,
  input logic            i_rst,
  fp_norm_round_if.slave bus
);

  // Normalized mantissa drops the implicit one: frac, guard, round, 2 sticky.
  localparam int NORM_W = SIZE_DATA - 1;
  localparam int GUARD  = SIZE_DATA - 2 - SIZE_FRAC;

  logic ready_en;
  logic ld1, ld2, ld3;

  logic                 s1_valid, s1_sign, s1_ovf, s1_zero;
  logic [SIZE_EXP-1:0]  s1_exp;
  logic [SIZE_DATA-1:0] s1_mant;
  logic [4:0]           s1_lzc;
  logic [4:0]           in_lzc;
  logic                 in_zero;

  logic                 s2_valid, s2_sign, s2_zero, s2_unf;
  logic [NORM_W-1:0]    s2_mant;
  exp_int_t             s2_exp;

  logic [NORM_W-1:0]    norm_mant;
  exp_int_t             norm_exp, exp_in, lzc_in;
  logic                 norm_zero, norm_unf;

  logic                 lsb, guard_b, round_b, sticky_b, round_up;
  logic [SIZE_FRAC:0]   frac_sum;
  exp_int_t             rnd_exp;
  fp32_t                res_next;
  logic                 ovf_next, unf_next, inex_next;

  logic                 s3_valid, s3_ovf, s3_unf, s3_inex;
  fp32_t                s3_result;

  assign ld3 = !s3_valid || bus.i_ready;
  assign ld2 = !s2_valid || ld3;
  assign ld1 = (!s1_valid || ld2) && ready_en;
  assign bus.o_ready = ld1;

  lzc_28 u_lzc (
    .value    (bus.i_mantissa),
    .count    (in_lzc),
    .all_zero (in_zero)
  );

  // Hold off the input side for the first cycle after reset is released.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Stage 1: capture the incoming beat together with its leading-zero count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_lzc   <= '0;
    end else if (ld1) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sign <= bus.i_sign;
        s1_ovf  <= bus.i_overflow;
        s1_zero <= in_zero;
        s1_exp  <= bus.i_exponent;
        s1_mant <= bus.i_mantissa;
        s1_lzc  <= in_lzc;
      end
    end
  end

  // Normalize: fold the carry-out back in, or shift out leading zeros.
  always_comb begin
    exp_in    = {{(EXP_INT_W-SIZE_EXP){1'b0}}, s1_exp};
    lzc_in    = {{(EXP_INT_W-5){1'b0}}, s1_lzc};
    norm_mant = '0;
    norm_exp  = '0;
    norm_zero = 1'b0;
    norm_unf  = 1'b0;
    if (s1_ovf) begin
      norm_mant = {s1_mant[SIZE_DATA-1:2], s1_mant[1] | s1_mant[0]};
      norm_exp  = exp_in + exp_int_t'(1);
    end else if (s1_zero) begin
      norm_zero = 1'b1;
    end else if (lzc_in >= exp_in) begin
      norm_unf  = 1'b1;
    end else begin
      norm_mant = s1_mant[NORM_W-1:0] << s1_lzc;
      norm_exp  = exp_in - lzc_in;
    end
  end

  // Stage 2: register the normalized beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_unf   <= 1'b0;
      s2_mant  <= '0;
      s2_exp   <= '0;
    end else if (ld2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= norm_zero;
        s2_unf  <= norm_unf;
        s2_mant <= norm_mant;
        s2_exp  <= norm_exp;
      end
    end
  end

  // Round to nearest even, then resolve zero, underflow and overflow.
  always_comb begin
    lsb       = s2_mant[GUARD+1];
    guard_b   = s2_mant[GUARD];
    round_b   = s2_mant[GUARD-1];
    sticky_b  = |s2_mant[GUARD-2:0];
    round_up  = guard_b & (round_b | sticky_b | lsb);
    frac_sum  = {1'b0, s2_mant[NORM_W-1:GUARD+1]} + {{SIZE_FRAC{1'b0}}, round_up};
    rnd_exp   = s2_exp + {{(EXP_INT_W-1){1'b0}}, frac_sum[SIZE_FRAC]};
    res_next  = POS_ZERO;
    ovf_next  = 1'b0;
    unf_next  = 1'b0;
    inex_next = 1'b0;
    if (s2_zero) begin
      res_next = POS_ZERO;
    end else if (s2_unf) begin
      res_next.sign = s2_sign;
      unf_next      = 1'b1;
      inex_next     = 1'b1;
    end else if (rnd_exp >= exp_int_t'(FP_EXP_MAX)) begin
      res_next      = POS_INF;
      res_next.sign = s2_sign;
      ovf_next      = 1'b1;
      inex_next     = 1'b1;
    end else begin
      res_next.sign = s2_sign;
      res_next.exp  = rnd_exp[SIZE_EXP-1:0];
      res_next.frac = frac_sum[SIZE_FRAC-1:0];
      inex_next     = guard_b | round_b | sticky_b;
    end
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s3_valid  <= 1'b0;
      s3_result <= POS_ZERO;
      s3_ovf    <= 1'b0;
      s3_unf    <= 1'b0;
      s3_inex   <= 1'b0;
    end else if (ld3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_result <= res_next;
        s3_ovf    <= ovf_next;
        s3_unf    <= unf_next;
        s3_inex   <= inex_next;
      end
    end
  end

  assign bus.o_valid        = s3_valid;
  assign bus.o_result       = s3_result;
  assign bus.o_flag_ovf     = s3_ovf;
  assign bus.o_flag_unf     = s3_unf;
  assign bus.o_flag_inexact = s3_inex;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed spec cases, randomized
// traffic against an arithmetic reference model, stall and reset scenarios.
module tb_fp_norm_round;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [34:0] exp_q [$];

  always #5 clk = ~clk;

  fp_norm_round_if bus ();

  fp_norm_round dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Inputs with an inf/NaN exponent must never reach this block.
  always @(posedge clk) begin
    if (!rst && bus.i_valid && bus.o_ready)
      assert (bus.i_exponent != 8'hFF) else $error("[TB] exponent 255 presented to the block");
  end

  // Value = ({ovf,mant} / 2^27) * 2^(e-bias); returns {ovf,unf,inexact,result}.
  function automatic logic [34:0] ref_model(input logic s, input logic [7:0] e,
                                            input logic [27:0] m, input logic o);
    longint v, keep, rem, half;
    int p, ex;
    logic fi;
    v = (longint'(o) << 28) | longint'(m);
    if (v == 0) return {3'b000, 32'h0};
    p = 28;
    while (((v >> p) & 64'd1) == 0) p--;
    ex = int'(e) + p - 27;
    if (ex <= 0) return {3'b011, s, 31'h0};
    fi = 1'b0;
    if (p > 23) begin
      keep = v >> (p - 23);
      rem  = v & ((64'd1 << (p - 23)) - 1);
      half = 64'd1 << (p - 24);
      fi   = (rem != 0);
      if (rem > half || (rem == half && (keep & 64'd1) == 1)) keep = keep + 1;
    end else begin
      keep = v << (23 - p);
    end
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      ex   = ex + 1;
    end
    if (ex >= FP_EXP_MAX) return {3'b101, s, 8'hFF, 23'h0};
    return {2'b00, fi, s, 8'(ex), 23'(keep)};
  endfunction

  // One clock: drive inputs, sample just after, record accepted beats.
  task automatic tick(input logic v, input logic s, input logic [7:0] e,
                      input logic [27:0] m, input logic o, input logic rdy,
                      output logic acc, output logic ov, output logic [34:0] obs);
    bus.i_valid    = v;
    bus.i_sign     = s;
    bus.i_exponent = e;
    bus.i_mantissa = m;
    bus.i_overflow = o;
    bus.i_ready    = rdy;
    #1;
    acc = v && bus.o_ready;
    ov  = bus.o_valid;
    obs = {bus.o_flag_ovf, bus.o_flag_unf, bus.o_flag_inexact, bus.o_result};
    if (acc) exp_q.push_back(ref_model(s, e, m, o));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_beat(output logic s, output logic [7:0] e,
                           output logic [27:0] m, output logic o);
    int sel;
    s   = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 3);
    if (sel == 0)      e = 8'($urandom_range(0, 30));
    else if (sel == 1) e = 8'($urandom_range(235, 254));
    else               e = 8'($urandom_range(1, 254));
    m = 28'($urandom()) >> $urandom_range(0, 28);
    if ($urandom_range(0, 3) == 0) m[3:0] = 4'b1000;
    o = ($urandom_range(0, 4) == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_sign = 1'b0; bus.i_exponent = '0;
    bus.i_mantissa = '0; bus.i_overflow = 1'b0; bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset o_valid: got %b expected 0", bus.o_valid);
    end
    vectors++;
    if (bus.o_result !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset o_result: got %h expected 00000000", bus.o_result);
    end
    vectors++;
    if ({bus.o_flag_ovf, bus.o_flag_unf, bus.o_flag_inexact} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset flags: got %b expected 000",
               {bus.o_flag_ovf, bus.o_flag_unf, bus.o_flag_inexact});
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset o_ready: got %b expected 1", bus.o_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    string       names [9] = '{"one_plus_one", "half", "tie_even", "tie_odd", "ovf_carry",
                               "ovf_round", "zero", "underflow", "negative"};
    logic        sgn  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0]  expn [9] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd254, 8'd100, 8'd3, 8'd130};
    logic [27:0] mant [9] = '{28'h0, 28'h4000000, 28'h8000008, 28'h8000018, 28'h0,
                              28'hFFFFFFF, 28'h0, 28'h0000100, 28'h8000000};
    logic        ovfi [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] res  [9] = '{32'h40000000, 32'h3F000000, 32'h3F800000, 32'h3F800002, 32'h7F800000,
                              32'h7F800000, 32'h00000000, 32'h80000000, 32'hC1000000};
    logic [2:0]  flg  [9] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b101, 3'b101, 3'b000, 3'b011, 3'b000};
    for (int i = 0; i < 9; i++) begin
      logic acc, junk, ov;
      logic [34:0] obs, got_obs;
      int lat;
      got_obs = 'x;
      lat = 0;
      tick(1'b1, sgn[i], expn[i], mant[i], ovfi[i], 1'b1, acc, ov, obs);
      if (acc) begin
        for (int k = 1; k <= 8; k++) begin
          tick(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b1, junk, ov, obs);
          if (ov && lat == 0) begin
            lat = k;
            got_obs = obs;
          end
        end
      end
      vectors++;
      if (lat != 3) begin
        miscompares++; $display("[TB] FAIL %s latency: got %0d expected 3", names[i], lat);
      end
      vectors++;
      if (got_obs[31:0] !== res[i]) begin
        miscompares++; $display("[TB] FAIL %s result: got %h expected %h", names[i], got_obs[31:0], res[i]);
      end
      vectors++;
      if (got_obs[34:32] !== flg[i]) begin
        miscompares++;
        $display("[TB] FAIL %s flags ovf/unf/inex: got %b expected %b", names[i], got_obs[34:32], flg[i]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic s, o, acc, ov, rdy, v;
    logic [7:0] e;
    logic [27:0] m;
    logic [34:0] obs, expv;
    for (int n = 0; n < 400; n++) begin
      rand_beat(s, e, m, o);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(v, s, e, m, o, rdy, acc, ov, obs);
      if (ov && rdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL random unexpected beat: got %h expected none", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            miscompares++; $display("[TB] FAIL random beat %0d: got %h expected %h", n, obs, expv);
          end
        end
      end
    end
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      tick(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b1, acc, ov, obs);
      if (ov) begin
        expv = exp_q.pop_front();
        vectors++;
        if (obs !== expv) begin
          miscompares++; $display("[TB] FAIL random drain: got %h expected %h", obs, expv);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("[TB] FAIL random drain left: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic        bs [6];
    logic [7:0]  be [6];
    logic [27:0] bm [6];
    logic        bo [6];
    logic acc, ov, seen;
    logic [34:0] obs, held, expv;
    int idx, outs;
    exp_q.delete();
    for (int i = 0; i < 6; i++) rand_beat(bs[i], be[i], bm[i], bo[i]);
    idx = 0;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, bs[idx], be[idx], bm[idx], bo[idx], 1'b0, acc, ov, obs);
      if (acc) idx++;
      if (ov) begin
        if (seen) begin
          vectors++;
          if (obs !== held) begin
            miscompares++; $display("[TB] FAIL stall hold: got %h expected %h", obs, held);
          end
        end
        seen = 1'b1;
        held = obs;
      end
    end
    vectors++;
    if (idx != 3) begin
      miscompares++; $display("[TB] FAIL stall accepted count: got %0d expected 3", idx);
    end
    vectors++;
    if (bus.o_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL stall o_ready: got %b expected 0", bus.o_ready);
    end
    outs = 0;
    for (int c = 0; c < 30 && outs < 6; c++) begin
      if (idx < 6) tick(1'b1, bs[idx], be[idx], bm[idx], bo[idx], 1'b1, acc, ov, obs);
      else         tick(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b1, acc, ov, obs);
      if (acc) idx++;
      if (ov) begin
        outs++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("[TB] FAIL stall extra beat: got %h expected none", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            miscompares++; $display("[TB] FAIL stall beat %0d: got %h expected %h", outs, obs, expv);
          end
        end
      end
    end
    vectors++;
    if (outs != 6) begin
      miscompares++; $display("[TB] FAIL stall beats out: got %0d expected 6", outs);
    end
  endtask

  task automatic test_reset_midstream();
    logic s, o, acc, ov;
    logic [7:0] e;
    logic [27:0] m;
    logic [34:0] obs, expv;
    int stale, outs;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      rand_beat(s, e, m, o);
      tick(1'b1, s, e, m, o, 1'b1, acc, ov, obs);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midreset o_valid: got %b expected 0", bus.o_valid);
    end
    vectors++;
    if (bus.o_result !== 32'h0) begin
      miscompares++; $display("[TB] FAIL midreset o_result: got %h expected 00000000", bus.o_result);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b1, acc, ov, obs);
      if (ov) stale++;
    end
    vectors++;
    if (stale != 0) begin
      miscompares++; $display("[TB] FAIL midreset stale beats: got %0d expected 0", stale);
    end
    rand_beat(s, e, m, o);
    tick(1'b1, s, e, m, o, 1'b1, acc, ov, obs);
    outs = 0;
    for (int c = 0; c < 8; c++) begin
      tick(1'b0, 1'b0, 8'd0, 28'd0, 1'b0, 1'b1, acc, ov, obs);
      if (ov && exp_q.size() > 0) begin
        outs++;
        expv = exp_q.pop_front();
        vectors++;
        if (obs !== expv) begin
          miscompares++; $display("[TB] FAIL midreset recovery: got %h expected %h", obs, expv);
        end
      end
    end
    vectors++;
    if (outs != 1) begin
      miscompares++; $display("[TB] FAIL midreset recovery beats: got %0d expected 1", outs);
    end
  endtask

  initial begin
    $display("[TB] fp_norm_round bench start");
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Downstream consumer of the mantissa add/sub pipeline.
- Takes the raw sum/difference mantissa, carry-out, result sign and pre-normalization exponent, and produces a packed IEEE-754 single-precision result.
- Normalizes with a leading-zero count and shift, rounds to nearest-even, and detects overflow, underflow and inexact.
- 3-stage valid/ready pipeline with per-stage stall so it can sit before a backpressuring writeback stage.

Parameters:
- SIZE_DATA, 28, input mantissa width: bit27 = integer bit, [26:4] fraction, [3] guard, [2] round, [1:0] sticky.
- SIZE_EXP, 8, biased exponent width.
- SIZE_FRAC, 23, output fraction width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_sign  in  1  result sign from mantissa unit
- i_exponent  in  SIZE_EXP  biased exponent of the larger operand
- i_mantissa  in  SIZE_DATA  unnormalized magnitude
- i_overflow  in  1  carry-out, weight 2.0
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  32  {sign, exp[7:0], frac[22:0]}
- o_flag_ovf  out  1  result overflowed to infinity
- o_flag_unf  out  1  result flushed to zero
- o_flag_inexact  out  1  rounding or flush discarded nonzero bits

Behaviour:
- Reset: all stage valids 0; o_valid=0, o_result=0, all flags 0; o_ready=1 one cycle after reset deasserts. Reset mid-operation discards in-flight beats immediately, asynchronously.
- Handshake:
  - A beat transfers when valid&ready on either side.
  - Stage k loads when stage k is empty or stage k+1 loads (or, for stage 3, i_ready=1).
  - o_ready = stage-1 load enable.
  - o_result and flags hold stable while o_valid=1 and i_ready=0.
  - Latency is exactly 3 cycles from accept to o_valid with no stall. Full throughput: 1 beat/cycle.
  - Order is preserved; no beat is lost or duplicated.
- Stage 1:
  - Register inputs.
  - Compute lzc = leading zeros of i_mantissa (0..28) via sub-module.
- Stage 2, normalize:
  - If i_overflow: shift {1, mantissa} right by 1; OR the dropped bit into sticky; exp = i_exponent+1.
  - Else if mantissa==0: mark exact zero.
  - Else if lzc >= i_exponent: underflow; flush to zero. No subnormals.
  - Else: shift left by lzc; exp = i_exponent - lzc.
  - Use a 10-bit signed internal exponent; no wrap is allowed.
- Stage 3, round RNE:
  - Compute lsb, G, R, S = OR(sticky bits).
  - round_up = G & (R | S | lsb).
  - 24-bit significand+1 carry to 2^24 → frac=0, exp+1.
  - exp >= 255 after any step → ±inf (exp=255, frac=0), o_flag_ovf=1, o_flag_inexact=1.
  - Exact zero → +0 (0x00000000) regardless of i_sign; flags 0.
  - Underflow → signed zero with i_sign, o_flag_unf=1, o_flag_inexact=1.
  - o_flag_inexact = G|R|S in the normal path.
- Input constraint: i_exponent=255 (inf/NaN) is excluded from this block; special cases are bypassed upstream. A bench assertion flags any violation.

Decomposition:
- Shared package fp_pkg holds:
  - FP_EXP_W=8, FP_FRAC_W=23, FP_BIAS=127, FP_EXP_MAX=255.
  - Typedef fp32_t as a packed struct {sign, exp, frac}.
  - Constants POS_ZERO and POS_INF.
- Sub-module lzc_28: combinational leading-zero counter, 28-bit input, 5-bit count, all-zero flag.
- Stage registers and handshake stay in fp_norm_round.

Test Plan:
- 1.0+1.0: i_overflow=1, i_mantissa=0, i_exponent=127, i_sign=0 → after 3 cycles o_result=0x40000000, all flags 0.
- 1.5-1.0: i_mantissa=0x4000000, i_exponent=127 → 0x3F000000.
- Rounding, both with i_exponent=127:
  - Tie, even lsb: i_mantissa=0x8000008 → 0x3F800000, inexact=1.
  - Tie, odd lsb: i_mantissa=0x8000018 → 0x3F800002, inexact=1.
- Overflow:
  - i_exponent=254, i_overflow=1 → 0x7F800000, o_flag_ovf=1.
  - i_mantissa=0xFFFFFFF, i_exponent=254 → round carry → 0x7F800000.
- Zero and underflow:
  - i_mantissa=0, i_sign=1 → 0x00000000, flags 0.
  - i_mantissa=0x0000100, i_exponent=3, i_sign=1 → 0x80000000, o_flag_unf=1.
- Backpressure and reset:
  - Stream 6 back-to-back beats with i_ready=0 for 5 cycles → o_ready drops after 3 accepted; o_result held stable; all 6 results emerge in order once i_ready=1.
  - Assert i_rst mid-stream → o_valid=0 in the same cycle, with no stale output after release.
